freq_divider_prog: RTL and testbench

Parametrised, runtime-programmable frequency divider for the stopwatch timebase. It divides the board clock `CLK` by a ratio taken from the `DIV` port and emits a one-cycle `TICK` clock-enable plus a `CLK_OUT` divided output. It replaces the fixed divide-by-4 ripple chain: the design stays fully synchronous on `CLK`, and the ratio can change without glitches. Downstream counters (centiseconds, seconds, display scan) use `TICK` as an enable, never as a clock.

---
 rtl/freq_divider_pkg.sv | 21 ++
 rtl/div_counter.sv | 85 ++++++++
 rtl/freq_divider_prog.sv | 88 ++++++++
 tb/tb_freq_divider_prog.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_divider_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : freq_divider_pkg
// Purpose  : Shared constants and types for the programmable stopwatch timebase
//            divider (default widths, reset ratio, common tick ratios).
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package freq_divider_pkg;

   localparam int          DIV_WIDTH_DEF   = 26;
   localparam int unsigned DIV_DEFAULT_DEF = 50_000_000;

   // Common ratios from a 50 MHz board clock.
   localparam int unsigned DIV_1KHZ  = 50_000;
   localparam int unsigned DIV_100HZ = 500_000;

   typedef logic [DIV_WIDTH_DEF-1:0] div_t;

endpackage
`default_nettype wire

// File: rtl/div_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_counter
// Purpose  : Wrap counter and ratio latch for freq_divider_prog. Counts
//            0..n-1 while enabled and re-samples the requested ratio only on
//            wrap, so a ratio change never truncates a running period.
// Ports    : clk_i    - clock
//            rst_i    - synchronous active-high reset
//            en_i     - count enable
//            clear_i  - synchronous period restart (ratio kept)
//            div_i    - requested ratio
//            cnt_o    - registered counter value
//            wrap_o   - this edge ends the period (combinational)
//            half_o   - this edge ends the high half (FREQ_DIVIDER_DUTY50_EN only)
// Config   : FREQ_DIVIDER_DUTY50_EN adds half_o for the 50 % duty output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_counter
   import freq_divider_pkg::*;
#(
   parameter int          DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 clear_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic [DIV_WIDTH-1:0] cnt_o,
   output logic                 wrap_o
`ifdef FREQ_DIVIDER_DUTY50_EN
   ,
   output logic                 half_o
`endif
);

   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] ZERO    = '0;
   localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DIV_DEFAULT);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] n_w;
   logic                 wrap_w;

   // Ratios 0 and 1 both behave as divide-by-one.
   assign n_w    = (div_q > ONE) ? div_q : ONE;
   assign wrap_w = en_i && !clear_i && (cnt_q == n_w - ONE);

   always_comb begin
      cnt_d = cnt_q;
      div_d = div_q;
      if (clear_i) begin
         cnt_d = ZERO;
      end else if (wrap_w) begin
         cnt_d = ZERO;
         div_d = div_i;
      end else if (en_i) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= ZERO;
         div_q <= RST_DIV;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = wrap_w;

`ifdef FREQ_DIVIDER_DUTY50_EN
   logic [DIV_WIDTH-1:0] half_w;

   // For n=1 half_w-1 is all ones, which cnt can never reach: output stays high.
   assign half_w = n_w >> 1;
   assign half_o = en_i && !clear_i && !wrap_w && (cnt_q == half_w - ONE);
`endif

endmodule
`default_nettype wire

// File: rtl/freq_divider_prog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : freq_divider_prog
// Purpose  : Runtime-programmable, fully synchronous frequency divider for the
//            stopwatch timebase. Emits a one-cycle TICK clock enable per
//            period plus a divided CLK_OUT.
// Ports    : CLK     - clock
//            RST     - synchronous active-high reset
//            EN      - count enable (low: all state holds)
//            CLEAR   - synchronous restart of the current period
//            DIV     - requested ratio, taken at the next period boundary
//            TICK    - registered one-cycle pulse per period
//            CLK_OUT - divided output (square wave or copy of TICK)
//            COUNT   - current counter value
// Config   : FREQ_DIVIDER_DUTY50_EN - when defined CLK_OUT is a registered
//            ~50 % duty square wave; otherwise CLK_OUT is TICK.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module freq_divider_prog
   import freq_divider_pkg::*;
#(
   parameter int          DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic                 CLEAR,
   input  logic [DIV_WIDTH-1:0] DIV,
   output logic                 TICK,
   output logic                 CLK_OUT,
   output logic [DIV_WIDTH-1:0] COUNT
);

   logic wrap_w;
   logic tick_q;

`ifdef FREQ_DIVIDER_DUTY50_EN
   logic half_w;
   logic clk_out_q;
`endif

   div_counter #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) u_div_counter (
      .clk_i   (CLK),
      .rst_i   (RST),
      .en_i    (EN),
      .clear_i (CLEAR),
      .div_i   (DIV),
      .cnt_o   (COUNT),
      .wrap_o  (wrap_w)
`ifdef FREQ_DIVIDER_DUTY50_EN
      ,
      .half_o  (half_w)
`endif
   );

   // wrap_w is already false under CLEAR or EN=0, so TICK drops there too.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= wrap_w;
      end
   end

   assign TICK = tick_q;

`ifdef FREQ_DIVIDER_DUTY50_EN
   always_ff @(posedge CLK) begin
      if (RST || CLEAR) begin
         clk_out_q <= 1'b0;
      end else if (wrap_w) begin
         clk_out_q <= 1'b1;
      end else if (half_w) begin
         clk_out_q <= 1'b0;
      end
   end

   assign CLK_OUT = clk_out_q;
`else
   assign CLK_OUT = tick_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_prog.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_freq_divider_prog
// Purpose  : Self-checking bench for freq_divider_prog (DIV_WIDTH=8,
//            DIV_DEFAULT=4) with a period-level reference model.
// Config   : follows FREQ_DIVIDER_DUTY50_EN for the expected CLK_OUT.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_freq_divider_prog;

   localparam int W   = 8;
   localparam int DEF = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         clear = 1'b0;
   logic [W-1:0] div = 8'd4;
   logic         tick;
   logic         clk_out;
   logic [W-1:0] count;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: latched ratio and cycles remaining in the period.
   int m_ratio = DEF;
   int m_left  = DEF;
   bit m_tick  = 1'b0;
   bit m_clk   = 1'b0;

   freq_divider_prog #(.DIV_WIDTH(W), .DIV_DEFAULT(DEF)) dut (
      .CLK     (clk),
      .RST     (rst),
      .EN      (en),
      .CLEAR   (clear),
      .DIV     (div),
      .TICK    (tick),
      .CLK_OUT (clk_out),
      .COUNT   (count)
   );

   always #5 clk = ~clk;

   function automatic int eff(input int r);
      return (r <= 1) ? 1 : r;
   endfunction

   function automatic logic [W+1:0] exp_word();
      logic [W-1:0] c;
      bit           co;
      c = W'(eff(m_ratio) - m_left);
`ifdef FREQ_DIVIDER_DUTY50_EN
      co = m_clk;
`else
      co = m_tick;
`endif
      return {m_tick, co, c};
   endfunction

   task automatic model_step();
      int n;
      n = eff(m_ratio);
      if (rst) begin
         m_ratio = DEF; m_left = eff(DEF); m_tick = 0; m_clk = 0;
      end else if (clear) begin
         m_left = n; m_tick = 0; m_clk = 0;
      end else if (en) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_tick = 1; m_clk = 1;
            m_ratio = int'(div);
            m_left = eff(m_ratio);
         end else begin
            m_tick = 0;
            // Elapsed cycles in the period reached the high-half length.
            if (n - m_left == (n >> 1)) m_clk = 0;
         end
      end else begin
         m_tick = 0;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; en = 0; clear = 0; div = 8'd4;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if ({tick, clk_out, count} !== {2'b00, 8'd0})
            $display("FAIL reset cyc%0d: tick/clk/count=%b/%b/%0d required 0/0/0", i, tick, clk_out, count);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      rst = 0; en = 1; div = 8'd4;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         n_checks++;
         if ({tick, clk_out, count} !== exp_word())
            $display("FAIL basic cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
         // COUNT runs 1,2,3,0 with TICK only on the 0 after each 4th edge.
         n_checks++;
         if (count !== W'(i % 4) || tick !== (i % 4 == 0))
            $display("FAIL basic_seq cyc%0d: count=%0d tick=%b required count=%0d tick=%b", i, count, tick, i % 4, (i % 4 == 0));
         else n_pass++;
      end
   endtask

   task automatic test_ratio_change();
      int t1 = -1, t2 = -1;
      n_checks++;
      if (count !== 8'd0) $display("FAIL ratio_align: count=%0d required 0", count);
      else n_pass++;
      cyc();
      div = 8'd5;
      for (int i = 1; i <= 14; i++) begin
         cyc();
         if (tick === 1'b1) begin
            if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
         end
         n_checks++;
         if ({tick, clk_out, count} !== exp_word())
            $display("FAIL ratio cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
      n_checks++;
      if (t1 != 3 || t2 != 8)
         $display("FAIL ratio_period: ticks at %0d,%0d required 3,8", t1, t2);
      else n_pass++;
   endtask

   task automatic test_div01();
      for (int r = 0; r < 2; r++) begin
         div = W'(r);
         for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++;
            if ({tick, clk_out, count} !== exp_word())
               $display("FAIL div%0d cyc%0d: got %b required %b", r, i, {tick, clk_out, count}, exp_word());
            else n_pass++;
         end
      end
      n_checks++;
      if (tick !== 1'b1 || count !== 8'd0)
         $display("FAIL div01_steady: tick=%b count=%0d required 1/0", tick, count);
      else n_pass++;
   endtask

   task automatic test_en_stall();
      int k;
      div = 8'd4;
      for (int i = 0; i < 10; i++) cyc();
      k = 0;
      while (count !== 8'd2 && k < 20) begin cyc(); k++; end
      n_checks++;
      if (count !== 8'd2) $display("FAIL stall_sync: count=%0d required 2", count);
      else n_pass++;
      en = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if (count !== 8'd2 || tick !== 1'b0 || {tick, clk_out, count} !== exp_word())
            $display("FAIL stall cyc%0d: got %b required %b (count 2, tick 0)", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
      en = 1;
      for (int i = 1; i <= 2; i++) begin
         cyc();
         n_checks++;
         if (tick !== (i == 2) || {tick, clk_out, count} !== exp_word())
            $display("FAIL stall_resume cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
   endtask

   task automatic test_clear();
      int k = 0;
      while (count !== 8'd3 && k < 20) begin cyc(); k++; end
      n_checks++;
      if (count !== 8'd3) $display("FAIL clear_sync: count=%0d required 3", count);
      else n_pass++;
      clear = 1;
      cyc();
      clear = 0;
      n_checks++;
      if (tick !== 1'b0 || count !== 8'd0 || clk_out !== 1'b0)
         $display("FAIL clear_wrap: tick/clk/count=%b/%b/%0d required 0/0/0", tick, clk_out, count);
      else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_checks++;
         if (tick !== (i == 4) || {tick, clk_out, count} !== exp_word())
            $display("FAIL clear_after cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      div = 8'd7;
      while (count !== 8'd2 && k < 20) begin cyc(); k++; end
      rst = 1;
      cyc();
      rst = 0;
      n_checks++;
      if ({tick, clk_out, count} !== {2'b00, 8'd0})
         $display("FAIL reset_mid: tick/clk/count=%b/%b/%0d required 0/0/0", tick, clk_out, count);
      else n_pass++;
      for (int i = 1; i <= 11; i++) begin
         cyc();
         n_checks++;
         if ({tick, clk_out, count} !== exp_word() || (i == 4 && tick !== 1'b1))
            $display("FAIL reset_mid cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         clear = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) div = W'($urandom_range(0, 9));
         cyc();
         n_checks++;
         if ({tick, clk_out, count} !== exp_word())
            $display("FAIL random cyc%0d: got %b required %b", i, {tick, clk_out, count}, exp_word());
         else n_pass++;
      end
      rst = 0; clear = 0; en = 1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ratio_change();
      test_div01();
      test_en_stall();
      test_clear();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
